game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level game sequencer for the shooter.
- Consumes player-hit, enemy-alive and boss status from the enemy, boss and bullet stages; receives start_key from the keyboard decode stage.
- Produces gameover, life, the player visibility/blink flag (reimuE), score and a one-cycle restart pulse.
- Replaces the constant gameover tie-off to the player-movement block and takes over the life/blink function of the current life counter.

Parameters:
- START_LIVES, 3, lives loaded on game start (must fit in 2 bits).
- INVULN_TICKS, 8, frame ticks of invulnerability after a non-fatal hit.
- BANNER_TICKS, 32, frame ticks WIN/LOSE is held before a restart is accepted.
- ENM_PTS, 100, score added per enemy kill.
- BOSS_PTS, 1000, score added on boss defeat.

Ports:
- clk  input  1  system clock; all logic runs on this single clock.
- rst  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle pulse per game frame; gates every timer.
- start_key  input  1  level, start/restart key from keyboard decode.
- shot  input  1  level, player-hit indication from the enemy-bullet stage.
- enm_alive  input  4  one bit per enemy (enm1..enm4).
- boss_alive  input  1  boss present on screen.
- bosshp  input  10  boss hit points.
- state  output  3  current game state encoding.
- game_active  output  1  high in PLAY and BOSS only.
- gameover  output  1  high in WIN and LOSE.
- life  output  2  remaining lives.
- reimuE  output  1  player sprite enable.
- invuln  output  1  invulnerability window active.
- score  output  16  saturating score.
- reset_req  output  1  one-cycle pulse that clears downstream game modules.

Behaviour:
- Reset (rst=0, asynchronous) sets: state=TITLE, life=START_LIVES, score=0, reimuE=1, invuln=0, gameover=0, game_active=0, reset_req=0. All counters and edge registers are cleared.
- State encodings: TITLE=0, PLAY=1, BOSS=2, WIN=3, LOSE=4. Codes 5–7 are illegal and go to TITLE on the next clk.
- start_key is registered every clk; a rise is (current=1 & previous=0).
- TITLE:
  - A start_key rise moves the state to PLAY on the next clk.
  - The same edge reloads life=START_LIVES, sets score=0, clears invuln, and drives reset_req=1 for exactly one clk.
- PLAY:
  - boss_alive=1 moves the state to BOSS next clk.
  - Hits are processed as described below.
- BOSS:
  - bosshp==0 with boss_alive=1 moves the state to WIN and adds BOSS_PTS once.
- Hit handling (PLAY/BOSS only): sampled every clk when shot=1 and invuln=0.
  - If life>1: life decrements by 1, invuln=1, and the invuln counter loads INVULN_TICKS.
  - If life==1: life=0 and the state moves to LOSE.
  - shot is ignored while invuln=1.
  - If a fatal hit and bosshp==0 occur in the same clk, WIN wins: life is unchanged.
- Invuln counter:
  - Decrements only on tick.
  - invuln drops on the tick that brings the counter to 0.
  - reimuE toggles on every tick while invuln=1; it is forced to 1 when invuln=0 and in all non-play states.
- Score:
  - A falling edge on any enm_alive bit (registered every clk) in PLAY/BOSS adds ENM_PTS per falling bit, so up to 4*ENM_PTS can be added in one clk.
  - The sum is computed 17 bits wide and saturates at 16'hFFFF.
  - Score holds in WIN/LOSE/TITLE until the next start.
- WIN/LOSE:
  - gameover=1 and game_active=0.
  - The banner counter counts ticks up to BANNER_TICKS and then holds.
  - Once the counter has expired, a start_key rise returns the state to TITLE. A start_key rise before expiry is ignored, and start_key held high across expiry does not count as a rise.
- game_active and gameover are registered outputs, valid one clk after the state change.
- rst asserted in any state returns everything to reset values immediately.

Decomposition:
- Shared package holds:
  - the state encodings (TITLE..LOSE) and the state width;
  - SCORE_W=16, ENM_PTS, BOSS_PTS;
  - the life width.
- One sub-module, invuln_timer: inputs clk, rst, tick, load, load_val; outputs active and blink. It is reused later for boss phase timers.

Test Plan:
- Release rst, pulse start_key high 3 clks → exactly one reset_req pulse, state=1, life=3, score=0.
- In PLAY, shot high for 20 clks with tick every 4 clks → life=2 only. invuln drops after 8 ticks, and reimuE toggles 8 times.
- Three separated hits → life 3→2→1→0, state=4, gameover=1 one clk after the third hit.
- enm_alive 4'b1111→4'b0000 in one clk → score=400. Preload score near 16'hFFFF, then a kill → score=16'hFFFF.
- boss_alive=1 → state=2. Drive bosshp=0 and a fatal shot in the same clk → state=3, score+=1000, life=1.
- In WIN: start_key rise at tick 10 is ignored. Rise after tick 32 → state=0. Assert rst mid-invuln → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game sequencer: state codes, widths, score values.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_flow_ctrl_pkg;

   localparam int STATE_W  = 3;
   localparam int LIFE_W   = 2;
   localparam int SCORE_W  = 16;
   localparam int N_ENM    = 4;
   localparam int ENM_PTS  = 100;
   localparam int BOSS_PTS = 1000;

   typedef enum logic [STATE_W-1:0] {
      ST_TITLE = 3'd0,
      ST_PLAY  = 3'd1,
      ST_BOSS  = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_t;

   // Score plus increment, clamped at all-ones instead of wrapping.
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W:0]   b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + b;
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/game_flow_ctrl_invuln.sv
// Tick-driven down-counter with a blink flag; used for player invulnerability and boss phases.
// Latency: load visible one clk later; active drops on the tick that reaches zero.
// Backpressure: none; load always wins over tick.
module invuln_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             active,
   output logic             blink
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blink_q, blink_d;

   // Next count: load (including load of zero to cancel), else count down on tick while running.
   always_comb begin
      cnt_d   = cnt_q;
      blink_d = blink_q;
      if (load) begin
         cnt_d   = load_val;
         blink_d = 1'b1;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d   = cnt_q - CNT_W'(1);
         blink_d = ~blink_q;
      end else if (cnt_q == '0) begin
         blink_d = 1'b1;
      end
   end

   // Counter and blink registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         blink_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         blink_q <= blink_d;
      end
   end

   assign active = (cnt_q != '0);
   assign blink  = blink_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencer: title/play/boss/win/lose flow, lives, invulnerability blink, saturating score.
// Latency: state/life/score update one clk after the input; game_active/gameover one clk after state.
// Backpressure: none; all inputs are sampled every clk.
module game_flow_ctrl
   import game_flow_ctrl_pkg::*;
#(
   parameter int START_LIVES  = 3,
   parameter int INVULN_TICKS = 8,
   parameter int BANNER_TICKS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic                start_key,
   input  logic                shot,
   input  logic [N_ENM-1:0]    enm_alive,
   input  logic                boss_alive,
   input  logic [9:0]          bosshp,
   output logic [STATE_W-1:0]  state,
   output logic                game_active,
   output logic                gameover,
   output logic [LIFE_W-1:0]   life,
   output logic                reimuE,
   output logic                invuln,
   output logic [SCORE_W-1:0]  score,
   output logic                reset_req
);

   localparam int CNT_W = $clog2(INVULN_TICKS + 1);
   localparam int BAN_W = $clog2(BANNER_TICKS + 1);
   localparam int KIL_W = $clog2(N_ENM + 1);

   state_t             state_q, state_d;
   logic [LIFE_W-1:0]  life_q, life_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [BAN_W-1:0]   banner_q, banner_d;
   logic               start_q;
   logic [N_ENM-1:0]   enm_q;
   logic               game_active_q, game_active_d;
   logic               gameover_q, gameover_d;
   logic               reset_req_q, reset_req_d;

   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_load_val;
   logic               tmr_active;
   logic               tmr_blink;

   logic               start_rise;
   logic               in_play;
   logic               win;
   logic               hit;
   logic [N_ENM-1:0]   fall;
   logic [KIL_W-1:0]   kills;
   logic [SCORE_W:0]   add_pts;

   invuln_timer #(.CNT_W(CNT_W)) u_invuln (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .active   (tmr_active),
      .blink    (tmr_blink)
   );

   // Event decode: key edge, boss defeat, accepted hit, enemy kills this clk.
   always_comb begin
      start_rise = start_key & ~start_q;
      in_play    = (state_q == ST_PLAY) || (state_q == ST_BOSS);
      win        = (state_q == ST_BOSS) && boss_alive && (bosshp == 10'd0);
      // A boss defeat in the same clk as a hit takes precedence; the hit is dropped.
      hit        = in_play && shot && !tmr_active && !win;
      fall       = enm_q & ~enm_alive;
      kills      = '0;
      for (int i = 0; i < N_ENM; i++) begin
         kills = kills + KIL_W'(fall[i]);
      end
      add_pts = (SCORE_W+1)'(kills) * (SCORE_W+1)'(ENM_PTS)
              + (win ? (SCORE_W+1)'(BOSS_PTS) : '0);
   end

   // Next-state, lives, score, banner timer and invuln timer control.
   always_comb begin
      state_d      = state_q;
      life_d       = life_q;
      score_d      = score_q;
      banner_d     = '0;
      reset_req_d  = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;

      case (state_q)
         ST_TITLE: begin
            if (start_rise) begin
               state_d     = ST_PLAY;
               life_d      = LIFE_W'(START_LIVES);
               score_d     = '0;
               tmr_load    = 1'b1;
               reset_req_d = 1'b1;
            end
         end
         ST_PLAY: begin
            if (boss_alive) state_d = ST_BOSS;
         end
         ST_BOSS: begin
            if (win) state_d = ST_WIN;
         end
         ST_WIN, ST_LOSE: begin
            banner_d = banner_q;
            if (tick && (banner_q < BAN_W'(BANNER_TICKS))) banner_d = banner_q + BAN_W'(1);
            if (start_rise && (banner_q == BAN_W'(BANNER_TICKS))) state_d = ST_TITLE;
         end
         default: state_d = ST_TITLE;
      endcase

      if (hit) begin
         if (life_q > LIFE_W'(1)) begin
            life_d       = life_q - LIFE_W'(1);
            tmr_load     = 1'b1;
            tmr_load_val = CNT_W'(INVULN_TICKS);
         end else begin
            life_d  = '0;
            state_d = ST_LOSE;
         end
      end

      // Leaving play on a boss defeat cancels any running invulnerability.
      if (win) tmr_load = 1'b1;

      if (in_play) score_d = sat_add(score_q, add_pts);

      game_active_d = (state_q == ST_PLAY) || (state_q == ST_BOSS);
      gameover_d    = (state_q == ST_WIN) || (state_q == ST_LOSE);
   end

   // State, counters, edge-detect history and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_TITLE;
         life_q        <= LIFE_W'(START_LIVES);
         score_q       <= '0;
         banner_q      <= '0;
         start_q       <= 1'b0;
         enm_q         <= '0;
         game_active_q <= 1'b0;
         gameover_q    <= 1'b0;
         reset_req_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         life_q        <= life_d;
         score_q       <= score_d;
         banner_q      <= banner_d;
         start_q       <= start_key;
         enm_q         <= enm_alive;
         game_active_q <= game_active_d;
         gameover_q    <= gameover_d;
         reset_req_q   <= reset_req_d;
      end
   end

   assign state       = state_q;
   assign life        = life_q;
   assign score       = score_q;
   assign game_active = game_active_q;
   assign gameover    = gameover_q;
   assign reset_req   = reset_req_q;
   assign invuln      = tmr_active;
   // Sprite only blinks during play; it is always shown on title and banner screens.
   assign reimuE      = in_play ? tmr_blink : 1'b1;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: full game sequences with hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_game_flow_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        tick;
   logic        start_key;
   logic        shot;
   logic [3:0]  enm_alive;
   logic        boss_alive;
   logic [9:0]  bosshp;
   logic [2:0]  state;
   logic        game_active;
   logic        gameover;
   logic [1:0]  life;
   logic        reimuE;
   logic        invuln;
   logic [15:0] score;
   logic        reset_req;

   int pass_cnt  = 0;
   int total_cnt = 0;

   game_flow_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .start_key   (start_key),
      .shot        (shot),
      .enm_alive   (enm_alive),
      .boss_alive  (boss_alive),
      .bosshp      (bosshp),
      .state       (state),
      .game_active (game_active),
      .gameover    (gameover),
      .life        (life),
      .reimuE      (reimuE),
      .invuln      (invuln),
      .score       (score),
      .reset_req   (reset_req)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Hit the player, then tick every clk until invulnerability ends (bounded).
   task automatic do_hit(input string tag);
      shot = 1'b1;
      cyc();
      shot = 1'b0;
      tick = 1'b1;
      for (int i = 0; i < 40 && invuln; i++) cyc();
      tick = 1'b0;
      total_cnt++;
      if (invuln !== 1'b0) $display("FAIL %s_invuln_timeout got %0b exp 0", tag, invuln);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b0; tick = 0; start_key = 0; shot = 0;
      enm_alive = 4'b1111; boss_alive = 0; bosshp = 10'd500;
      repeat (3) cyc();
      total_cnt++; if (state !== 3'd0) $display("FAIL rst_state got %0d exp 0", state); else pass_cnt++;
      total_cnt++; if (life !== 2'd3) $display("FAIL rst_life got %0d exp 3", life); else pass_cnt++;
      total_cnt++; if (score !== 16'd0) $display("FAIL rst_score got %0d exp 0", score); else pass_cnt++;
      total_cnt++; if ({reimuE, invuln, gameover, game_active, reset_req} !== 5'b10000)
         $display("FAIL rst_flags got %b exp 10000", {reimuE, invuln, gameover, game_active, reset_req});
      else pass_cnt++;
      rst = 1'b1;
      cyc();
   endtask

   task automatic test_start(input string tag);
      int rr;
      rr = 0;
      start_key = 1'b1;
      repeat (3) begin cyc(); if (reset_req) rr++; end
      start_key = 1'b0;
      repeat (2) begin cyc(); if (reset_req) rr++; end
      total_cnt++; if (rr !== 1) $display("FAIL %s_rreq_pulses got %0d exp 1", tag, rr); else pass_cnt++;
      total_cnt++; if (state !== 3'd1) $display("FAIL %s_state got %0d exp 1", tag, state); else pass_cnt++;
      total_cnt++; if (life !== 2'd3) $display("FAIL %s_life got %0d exp 3", tag, life); else pass_cnt++;
      total_cnt++; if (score !== 16'd0) $display("FAIL %s_score got %0d exp 0", tag, score); else pass_cnt++;
      total_cnt++; if (game_active !== 1'b1) $display("FAIL %s_active got %0b exp 1", tag, game_active); else pass_cnt++;
   endtask

   task automatic test_invuln();
      int toggles, ticks_in, drop_ticks;
      logic prev_re, pre_inv;
      toggles = 0; ticks_in = 0; drop_ticks = -1;
      prev_re = reimuE;
      for (int i = 0; i < 60; i++) begin
         shot = (i < 20);
         tick = ((i % 4) == 3);
         pre_inv = invuln;
         if (tick && pre_inv) ticks_in++;
         cyc();
         if (reimuE !== prev_re) toggles++;
         prev_re = reimuE;
         if (pre_inv && !invuln && drop_ticks < 0) drop_ticks = ticks_in;
      end
      shot = 0; tick = 0;
      total_cnt++; if (life !== 2'd2) $display("FAIL inv_life got %0d exp 2", life); else pass_cnt++;
      total_cnt++; if (drop_ticks !== 8) $display("FAIL inv_drop_ticks got %0d exp 8", drop_ticks); else pass_cnt++;
      total_cnt++; if (toggles !== 8) $display("FAIL inv_toggles got %0d exp 8", toggles); else pass_cnt++;
      total_cnt++; if ({invuln, reimuE} !== 2'b01) $display("FAIL inv_end got %b exp 01", {invuln, reimuE}); else pass_cnt++;
   endtask

   task automatic test_score();
      enm_alive = 4'b0000; cyc();
      total_cnt++; if (score !== 16'd400) $display("FAIL score_x4 got %0d exp 400", score); else pass_cnt++;
      enm_alive = 4'b1111; cyc();
      enm_alive = 4'b0101; cyc();
      total_cnt++; if (score !== 16'd600) $display("FAIL score_x2 got %0d exp 600", score); else pass_cnt++;
      for (int i = 0; i < 162; i++) begin
         enm_alive = 4'b1111; cyc();
         enm_alive = 4'b0000; cyc();
      end
      total_cnt++; if (score !== 16'd65400) $display("FAIL score_bulk got %0d exp 65400", score); else pass_cnt++;
      enm_alive = 4'b1111; cyc();
      enm_alive = 4'b1110; cyc();
      total_cnt++; if (score !== 16'd65500) $display("FAIL score_x1 got %0d exp 65500", score); else pass_cnt++;
      enm_alive = 4'b1111; cyc();
      enm_alive = 4'b0000; cyc();
      total_cnt++; if (score !== 16'hFFFF) $display("FAIL score_sat got %h exp ffff", score); else pass_cnt++;
      enm_alive = 4'b1111; cyc();
   endtask

   task automatic test_hits();
      do_hit("hit1");
      total_cnt++; if (life !== 2'd1) $display("FAIL hits_life1 got %0d exp 1", life); else pass_cnt++;
      shot = 1'b1; cyc(); shot = 1'b0;
      total_cnt++; if ({state, life} !== {3'd4, 2'd0}) $display("FAIL hits_fatal got %0d/%0d exp 4/0", state, life); else pass_cnt++;
      total_cnt++; if (gameover !== 1'b0) $display("FAIL hits_go_early got %0b exp 0", gameover); else pass_cnt++;
      cyc();
      total_cnt++; if ({gameover, game_active} !== 2'b10) $display("FAIL hits_go got %b exp 10", {gameover, game_active}); else pass_cnt++;
   endtask

   task automatic test_lose_exit();
      tick = 1'b1; repeat (40) cyc(); tick = 1'b0;
      start_key = 1'b1; cyc();
      total_cnt++; if (state !== 3'd0) $display("FAIL lose_exit_state got %0d exp 0", state); else pass_cnt++;
      start_key = 1'b0; cyc();
      total_cnt++; if (gameover !== 1'b0) $display("FAIL lose_exit_go got %0b exp 0", gameover); else pass_cnt++;
   endtask

   task automatic test_boss_win();
      test_start("start2");
      do_hit("g2hit1");
      do_hit("g2hit2");
      total_cnt++; if (life !== 2'd1) $display("FAIL boss_pre_life got %0d exp 1", life); else pass_cnt++;
      enm_alive = 4'b1011; cyc();
      total_cnt++; if (score !== 16'd100) $display("FAIL boss_kill got %0d exp 100", score); else pass_cnt++;
      boss_alive = 1'b1; cyc();
      total_cnt++; if (state !== 3'd2) $display("FAIL boss_enter got %0d exp 2", state); else pass_cnt++;
      bosshp = 10'd0; shot = 1'b1; cyc(); shot = 1'b0;
      total_cnt++; if (state !== 3'd3) $display("FAIL win_state got %0d exp 3", state); else pass_cnt++;
      total_cnt++; if (score !== 16'd1100) $display("FAIL win_score got %0d exp 1100", score); else pass_cnt++;
      total_cnt++; if (life !== 2'd1) $display("FAIL win_life got %0d exp 1", life); else pass_cnt++;
      cyc();
      total_cnt++; if ({gameover, game_active} !== 2'b10) $display("FAIL win_go got %b exp 10", {gameover, game_active}); else pass_cnt++;
   endtask

   task automatic test_banner();
      tick = 1'b1; repeat (10) cyc(); tick = 1'b0;
      start_key = 1'b1; cyc();
      total_cnt++; if (state !== 3'd3) $display("FAIL ban_t10 got %0d exp 3", state); else pass_cnt++;
      start_key = 1'b0; cyc();
      tick = 1'b1; repeat (21) cyc(); tick = 1'b0;
      start_key = 1'b1; cyc();
      total_cnt++; if (state !== 3'd3) $display("FAIL ban_t31 got %0d exp 3", state); else pass_cnt++;
      tick = 1'b1; cyc(); tick = 1'b0;
      repeat (2) cyc();
      total_cnt++; if (state !== 3'd3) $display("FAIL ban_held got %0d exp 3", state); else pass_cnt++;
      start_key = 1'b0; cyc();
      start_key = 1'b1; cyc();
      total_cnt++; if (state !== 3'd0) $display("FAIL ban_exit got %0d exp 0", state); else pass_cnt++;
      start_key = 1'b0; cyc();
   endtask

   task automatic test_async_reset();
      enm_alive = 4'b1111; boss_alive = 1'b0; bosshp = 10'd500; cyc();
      start_key = 1'b1; cyc(); start_key = 1'b0; cyc();
      shot = 1'b1; cyc(); shot = 1'b0;
      enm_alive = 4'b1110; tick = 1'b1; cyc(); tick = 1'b0;
      total_cnt++; if ({life, invuln, reimuE} !== {2'd2, 1'b1, 1'b0}) $display("FAIL ar_pre got %0d/%0b/%0b exp 2/1/0", life, invuln, reimuE); else pass_cnt++;
      total_cnt++; if (score !== 16'd100) $display("FAIL ar_pre_score got %0d exp 100", score); else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      total_cnt++; if ({state, life} !== {3'd0, 2'd3}) $display("FAIL ar_state_life got %0d/%0d exp 0/3", state, life); else pass_cnt++;
      total_cnt++; if (score !== 16'd0) $display("FAIL ar_score got %0d exp 0", score); else pass_cnt++;
      total_cnt++; if ({reimuE, invuln, gameover, game_active, reset_req} !== 5'b10000)
         $display("FAIL ar_flags got %b exp 10000", {reimuE, invuln, gameover, game_active, reset_req});
      else pass_cnt++;
      cyc();
      rst = 1'b1;
      cyc();
   endtask

   initial begin
      test_reset();
      test_start("start1");
      test_invuln();
      test_score();
      test_hits();
      test_lose_exit();
      test_boss_win();
      test_banner();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
